// File: rtl/seatbelt_chime_ctrl.sv
// Seat-belt warning sequencer: qualifies the violation, waits a grace period,
// then gates a bounded number of cadenced chimes before going silent.
module seatbelt_chime_ctrl #(
    parameter int unsigned GRACE_CYC  = 16,
    parameter int unsigned ON_CYC     = 4,
    parameter int unsigned OFF_CYC    = 4,
    parameter int unsigned MAX_CHIMES = 6,
    parameter int unsigned TMR_W      = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             DoorClose,
    input  logic             Ignition,
    input  logic             SeatBelt,
    output logic             Alarm,
    output logic             Warn,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] ChimeCnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRACE     = 3'd1,
        CHIME_ON  = 3'd2,
        CHIME_OFF = 3'd3,
        SILENCED  = 3'd4
    } state_t;

    localparam logic [TMR_W-1:0] GRACE_LOAD = TMR_W'(GRACE_CYC - 1);
    localparam logic [TMR_W-1:0] ON_LOAD    = TMR_W'(ON_CYC - 1);
    localparam logic [TMR_W-1:0] OFF_LOAD   = TMR_W'(OFF_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CHIMES);

    state_t           st;
    logic [TMR_W-1:0] timer;
    logic             viol;

    assign viol  = Ignition & DoorClose & ~SeatBelt;
    assign State = st;

    // Alarm is registered alongside the state so it is high exactly in CHIME_ON.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            st       <= IDLE;
            timer    <= '0;
            ChimeCnt <= '0;
            Alarm    <= 1'b0;
            Warn     <= 1'b0;
        end else begin
            Warn  <= Ignition & ~SeatBelt;
            Alarm <= 1'b0;
            case (st)
                IDLE: begin
                    if (viol) begin
                        st       <= GRACE;
                        timer    <= GRACE_LOAD;
                        ChimeCnt <= '0;
                    end
                end
                GRACE, CHIME_OFF: begin
                    if (!viol) begin
                        st <= IDLE;
                    end else if (timer == '0) begin
                        st       <= CHIME_ON;
                        timer    <= ON_LOAD;
                        ChimeCnt <= ChimeCnt + CNT_W'(1);
                        Alarm    <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                CHIME_ON: begin
                    if (!viol) begin
                        st <= IDLE;
                    end else if (timer == '0) begin
                        if (ChimeCnt == CNT_MAX) begin
                            st <= SILENCED;
                        end else begin
                            st    <= CHIME_OFF;
                            timer <= OFF_LOAD;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                        Alarm <= 1'b1;
                    end
                end
                SILENCED: begin
                    if (!viol) st <= IDLE;
                end
                // Corrupted state codes recover to IDLE.
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seatbelt_chime_ctrl.sv
// Directed bench for seatbelt_chime_ctrl with small timing parameters.
module tb_seatbelt_chime_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       DoorClose, Ignition, SeatBelt;
    logic       Alarm, Warn;
    logic [2:0] State;
    logic [3:0] ChimeCnt;

    int checks = 0;
    int errors = 0;

    seatbelt_chime_ctrl #(
        .GRACE_CYC(4), .ON_CYC(2), .OFF_CYC(3), .MAX_CHIMES(3), .TMR_W(8), .CNT_W(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .DoorClose(DoorClose), .Ignition(Ignition),
        .SeatBelt(SeatBelt), .Alarm(Alarm), .Warn(Warn), .State(State), .ChimeCnt(ChimeCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       d, i, b;
        logic       a, w;
        logic [2:0] s;
        logic [3:0] c;
    } vec_t;

    vec_t tbl[$];

    // One full violation episode: per-edge Alarm, State, ChimeCnt.
    int ep_a[17] = '{0,0,0,0,1,1,0,0,0,1,1,0,0,0,1,1,0};
    int ep_s[17] = '{1,1,1,1,2,2,3,3,3,2,2,3,3,3,2,2,4};
    int ep_c[17] = '{0,0,0,0,1,1,1,1,1,2,2,2,2,2,3,3,3};

    task automatic check(input string nm, input logic a, input logic w,
                         input logic [2:0] s, input logic [3:0] c);
        checks++;
        if (Alarm !== a || Warn !== w || State !== s || ChimeCnt !== c) begin
            errors++;
            $display("FAIL %s: got alarm=%b warn=%b state=%0d cnt=%0d, want alarm=%b warn=%b state=%0d cnt=%0d",
                     nm, Alarm, Warn, State, ChimeCnt, a, w, s, c);
        end
    endtask

    task automatic step(input string nm, input logic d, input logic i, input logic b,
                        input logic a, input logic w, input logic [2:0] s, input logic [3:0] c);
        DoorClose = d; Ignition = i; SeatBelt = b;
        @(posedge Clk); #1;
        check(nm, a, w, s, c);
    endtask

    function automatic vec_t mk(input logic d, input logic i, input logic b, input logic a,
                                input logic w, input logic [2:0] s, input logic [3:0] c);
        vec_t v;
        v.d = d; v.i = i; v.b = b; v.a = a; v.w = w; v.s = s; v.c = c;
        return v;
    endfunction

    initial begin
        Reset = 1'b1; DoorClose = 1'b0; Ignition = 1'b0; SeatBelt = 1'b0;

        // Episode, silenced hold, ignition off, then a fresh episode.
        for (int k = 0; k < 17; k++)
            tbl.push_back(mk(1, 1, 0, 1'(ep_a[k]), 1, 3'(ep_s[k]), 4'(ep_c[k])));
        tbl.push_back(mk(1, 1, 0, 0, 1, 3'd4, 4'd3));
        tbl.push_back(mk(1, 1, 0, 0, 1, 3'd4, 4'd3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'd0, 4'd3));
        for (int k = 0; k < 17; k++)
            tbl.push_back(mk(1, 1, 0, 1'(ep_a[k]), 1, 3'(ep_s[k]), 4'(ep_c[k])));
        tbl.push_back(mk(1, 1, 0, 0, 1, 3'd4, 4'd3));

        #12;
        check("reset", 0, 0, 3'd0, 4'd0);
        Reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++)
            step($sformatf("vec%0d", k), tbl[k].d, tbl[k].i, tbl[k].b,
                 tbl[k].a, tbl[k].w, tbl[k].s, tbl[k].c);

        // Violation removed after two grace cycles.
        step("s2_ign_off", 1, 0, 0, 0, 0, 3'd0, 4'd3);
        step("s2_g1",      1, 1, 0, 0, 1, 3'd1, 4'd0);
        step("s2_g2",      1, 1, 0, 0, 1, 3'd1, 4'd0);
        step("s2_drop",    1, 1, 1, 0, 0, 3'd0, 4'd0);
        step("s2_idle",    1, 1, 1, 0, 0, 3'd0, 4'd0);

        // Belt fastened during the second chime.
        for (int k = 0; k < 10; k++)
            step($sformatf("s3_e%0d", k), 1, 1, 0, 1'(ep_a[k]), 1, 3'(ep_s[k]), 4'(ep_c[k]));
        step("s3_belt",    1, 1, 1, 0, 0, 3'd0, 4'd2);
        step("s3_hold",    1, 1, 1, 0, 0, 3'd0, 4'd2);

        // Door open with ignition on, then closed: full grace restarts.
        for (int k = 0; k < 10; k++)
            step($sformatf("s4_open%0d", k), 0, 1, 0, 0, 1, 3'd0, 4'd2);
        step("s4_g0",      1, 1, 0, 0, 1, 3'd1, 4'd0);
        step("s4_g1",      1, 1, 0, 0, 1, 3'd1, 4'd0);
        step("s4_g2",      1, 1, 0, 0, 1, 3'd1, 4'd0);
        step("s4_g3",      1, 1, 0, 0, 1, 3'd1, 4'd0);
        step("s4_rise",    1, 1, 0, 1, 1, 3'd2, 4'd1);

        // Asynchronous reset pulse between edges during CHIME_ON.
        #1 Reset = 1'b1;
        #1 check("s6_async", 0, 0, 3'd0, 4'd0);
        #1 Reset = 1'b0;
        for (int k = 0; k < 7; k++)
            step($sformatf("s6_e%0d", k), 1, 1, 0, 1'(ep_a[k]), 1, 3'(ep_s[k]), 4'(ep_c[k]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
